// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCpuRd,
        StVidRd
    } arb_state_e;

    typedef enum logic {
        OwnCpu,
        OwnVid
    } arb_owner_e;

    localparam int unsigned STAT_W = 16;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating up-counter tracking how long the video requester has been losing arbitration.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = cnt_width(MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority, video anti-starvation, one access in flight.
// Define DMEM_ARB_STATS_EN to add the stat_conflicts / stat_vid_forced counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_conflicts,
    output logic [STAT_W-1:0] stat_vid_forced
`endif
);

    localparam int unsigned LAT_W = cnt_width(MEM_LAT);
    localparam logic [LAT_W-1:0] LatLoad = LAT_W'(MEM_LAT);

    arb_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             run_q;
    arb_owner_e       winner;
    logic             idle;
    logic             rd_done;
    logic             starve_sat;
    logic             starve_inc;

    // run_q keeps grants off until the first clock after reset release, so a request
    // held through reset cannot produce a grant while reset is still asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            lat_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        idle       = run_q && (state_q == StIdle);
        winner     = (vid_req && (!cpu_req || starve_sat)) ? OwnVid : OwnCpu;
        cpu_gnt    = idle && cpu_req && (winner == OwnCpu);
        vid_gnt    = idle && vid_req && (winner == OwnVid);
        starve_inc = idle && vid_req && !vid_gnt;
        rd_done    = (state_q != StIdle) && (lat_q == '0);

        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_gnt && !cpu_we) begin
                    state_d = StCpuRd;
                    lat_d   = LatLoad;
                end else if (vid_gnt) begin
                    state_d = StVidRd;
                    lat_d   = LatLoad;
                end
            end
            StCpuRd, StVidRd: begin
                if (rd_done) begin
                    state_d = StIdle;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        cpu_rvalid = (state_q == StCpuRd) && rd_done;
        vid_rvalid = (state_q == StVidRd) && rd_done;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        vid_rdata  = vid_rvalid ? mem_rdata : '0;

        mem_en    = cpu_gnt || vid_gnt;
        mem_we    = cpu_gnt && cpu_we;
        mem_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
        mem_wdata = mem_we ? cpu_wdata : '0;

        // A granted CPU read keeps the pipeline stalled until its data returns.
        cpu_stall = run_q && ((cpu_req && !cpu_gnt) || (cpu_gnt && !cpu_we) ||
                              ((state_q == StCpuRd) && !rd_done));
    end

    dmem_arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(starve_inc),
        .clr(vid_gnt),
        .sat(starve_sat)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] conf_q, forced_q;
    logic              vid_force;

    assign vid_force = vid_gnt && cpu_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_q   <= '0;
            forced_q <= '0;
        end else begin
            if (run_q && cpu_req && vid_req && (conf_q != '1)) begin
                conf_q <= conf_q + STAT_W'(1);
            end
            if (vid_force && (forced_q != '1)) begin
                forced_q <= forced_q + STAT_W'(1);
            end
        end
    end

    assign stat_conflicts  = conf_q;
    assign stat_vid_forced = forced_q;
`endif

endmodule
